// File: rtl/pid_sequencer_pkg.sv
// Shared word sizes and state encodings for the PID update sequencer.
package pid_sequencer_pkg;
    localparam int N = 18;
    localparam int F = 9;
    localparam int G = 4;
    localparam int W = N + G;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_MAC0  = 3'd2,
        ST_MAC1  = 3'd3,
        ST_MAC2  = 3'd4,
        ST_SAT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_E0 = 2'd0,
        SEL_E1 = 2'd1,
        SEL_E2 = 2'd2
    } mac_sel_t;
endpackage

// File: rtl/pid_sequencer_if.sv
// Sample/coefficient inputs and control outputs of the PID sequencer.
interface pid_sequencer_if;
    import pid_sequencer_pkg::*;

    logic                i_enable;
    logic                i_sample_tick;
    logic                i_clr_state;
    logic signed [N-1:0] i_ref;
    logic signed [N-1:0] i_yk;
    logic signed [N-1:0] i_a0;
    logic signed [N-1:0] i_a1;
    logic signed [N-1:0] i_a2;
    logic signed [N-1:0] o_uk;
    logic                o_uk_valid;
    logic                o_busy;
    logic                o_sat;
    logic                o_overrun;

    modport master (
        output i_enable, i_sample_tick, i_clr_state, i_ref, i_yk, i_a0, i_a1, i_a2,
        input  o_uk, o_uk_valid, o_busy, o_sat, o_overrun
    );

    modport slave (
        input  i_enable, i_sample_tick, i_clr_state, i_ref, i_yk, i_a0, i_a1, i_a2,
        output o_uk, o_uk_valid, o_busy, o_sat, o_overrun
    );
endinterface

// File: rtl/pid_sequencer_ek.sv
// Saturating error subtractor: e = clamp(ref - yk) to the signed N-bit range.
module pid_ek
    import pid_sequencer_pkg::*;
(
    input  logic signed [N-1:0] i_ref,
    input  logic signed [N-1:0] i_yk,
    output logic signed [N-1:0] o_e
);
    logic signed [N:0] w_diff;

    assign w_diff = (N+1)'(i_ref) - (N+1)'(i_yk);

    // Top two bits disagree only when the difference left the N-bit range.
    always_comb begin
        o_e = w_diff[N-1:0];
        if (w_diff[N] != w_diff[N-1]) begin
            o_e = w_diff[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end
endmodule

// File: rtl/pid_sequencer_mac.sv
// Single shared multiply-accumulate step: acc_out = base + ((coef * err) >>> F).
module pid_mac
    import pid_sequencer_pkg::*;
(
    input  mac_sel_t            i_sel,
    input  logic signed [N-1:0] i_a0,
    input  logic signed [N-1:0] i_a1,
    input  logic signed [N-1:0] i_a2,
    input  logic signed [N-1:0] i_e0,
    input  logic signed [N-1:0] i_e1,
    input  logic signed [N-1:0] i_e2,
    input  logic signed [N-1:0] i_uprev,
    input  logic signed [W-1:0] i_acc,
    output logic signed [W-1:0] o_acc
);
    logic signed [N-1:0]   w_coef;
    logic signed [N-1:0]   w_err;
    logic signed [2*N-1:0] w_prod;
    logic signed [W-1:0]   w_term;
    logic signed [W-1:0]   w_base;

    always_comb begin
        w_coef = i_a0;
        w_err  = i_e0;
        case (i_sel)
            SEL_E1: begin
                w_coef = i_a1;
                w_err  = i_e1;
            end
            SEL_E2: begin
                w_coef = i_a2;
                w_err  = i_e2;
            end
            default: ;
        endcase
    end

    assign w_prod = (2*N)'(w_coef) * (2*N)'(w_err);
    // The shifted product is narrowed to the accumulator width before the add.
    assign w_term = W'(w_prod >>> F);
    assign w_base = (i_sel == SEL_E0) ? W'(i_uprev) : i_acc;
    assign o_acc  = w_base + w_term;
endmodule

// File: rtl/pid_sequencer.sv
// Incremental PID update sequencer: one update per accepted sample tick, one shared MAC.
module pid_sequencer
    import pid_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    pid_sequencer_if.slave bus
);
    localparam logic signed [W-1:0] ACC_MAX = W'((2 ** (N - 1)) - 1);
    localparam logic signed [W-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [N-1:0] UK_MAX  = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] UK_MIN  = ~UK_MAX;

    state_t              r_state;
    logic signed [N-1:0] r_e0, r_e1, r_e2;
    logic signed [N-1:0] r_a0, r_a1, r_a2;
    logic signed [N-1:0] r_uprev, r_uk;
    logic signed [W-1:0] r_acc;
    logic                r_uk_valid, r_busy, r_sat, r_overrun;

    logic signed [N-1:0] w_e0;
    logic signed [N-1:0] w_uk_clamped;
    logic signed [W-1:0] w_acc_next;
    logic                w_hi, w_lo;
    mac_sel_t            w_sel;

    pid_ek u_ek (
        .i_ref (bus.i_ref),
        .i_yk  (bus.i_yk),
        .o_e   (w_e0)
    );

    always_comb begin
        w_sel = SEL_E0;
        case (r_state)
            ST_MAC1: w_sel = SEL_E1;
            ST_MAC2: w_sel = SEL_E2;
            default: ;
        endcase
    end

    pid_mac u_mac (
        .i_sel   (w_sel),
        .i_a0    (r_a0),
        .i_a1    (r_a1),
        .i_a2    (r_a2),
        .i_e0    (r_e0),
        .i_e1    (r_e1),
        .i_e2    (r_e2),
        .i_uprev (r_uprev),
        .i_acc   (r_acc),
        .o_acc   (w_acc_next)
    );

    assign w_hi = (r_acc > ACC_MAX);
    assign w_lo = (r_acc < ACC_MIN);

    always_comb begin
        w_uk_clamped = r_acc[N-1:0];
        if (w_hi) begin
            w_uk_clamped = UK_MAX;
        end else if (w_lo) begin
            w_uk_clamped = UK_MIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_e0       <= '0;
            r_e1       <= '0;
            r_e2       <= '0;
            r_a0       <= '0;
            r_a1       <= '0;
            r_a2       <= '0;
            r_uprev    <= '0;
            r_uk       <= '0;
            r_acc      <= '0;
            r_uk_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_sat      <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_uk_valid <= 1'b0;
            if (bus.i_sample_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    // Clear lands before an accepted tick's update reads the histories.
                    if (bus.i_clr_state) begin
                        r_e1      <= '0;
                        r_e2      <= '0;
                        r_uprev   <= '0;
                        r_overrun <= 1'b0;
                    end
                    if (bus.i_sample_tick && bus.i_enable) begin
                        r_state <= ST_LATCH;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    r_e0    <= w_e0;
                    r_a0    <= bus.i_a0;
                    r_a1    <= bus.i_a1;
                    r_a2    <= bus.i_a2;
                    r_state <= ST_MAC0;
                end
                ST_MAC0: begin
                    r_acc   <= w_acc_next;
                    r_state <= ST_MAC1;
                end
                ST_MAC1: begin
                    r_acc   <= w_acc_next;
                    r_state <= ST_MAC2;
                end
                ST_MAC2: begin
                    r_acc   <= w_acc_next;
                    r_state <= ST_SAT;
                end
                ST_SAT: begin
                    r_uk       <= w_uk_clamped;
                    r_uprev    <= w_uk_clamped;
                    r_sat      <= w_hi | w_lo;
                    r_uk_valid <= 1'b1;
                    r_e2       <= r_e1;
                    r_e1       <= r_e0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_uk       = r_uk;
    assign bus.o_uk_valid = r_uk_valid;
    assign bus.o_busy     = r_busy;
    assign bus.o_sat      = r_sat;
    assign bus.o_overrun  = r_overrun;
endmodule
